// File: rtl/mt32_pkg.sv
// Shared constants and state encoding for the MT19937 state-memory sequencer.
// Optional output tempering is selected by MT32_TEMPER_EN in mt32_ctrl.
package mt32_pkg;

    localparam int N       = 624;
    localparam int M       = 397;
    localparam int A_WIDTH = 10;

    localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
    localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
    localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
    localparam logic [31:0] INIT_MULT  = 32'd1812433253;

    localparam int          TEMPER_U = 11;
    localparam int          TEMPER_S = 7;
    localparam logic [31:0] TEMPER_B = 32'h9D2C_5680;
    localparam int          TEMPER_T = 15;
    localparam logic [31:0] TEMPER_C = 32'hEFC6_0000;
    localparam int          TEMPER_L = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_PRIME,
        ST_RUN
    } state_t;

endpackage

// File: rtl/mt32_temper.sv
// MT19937 output tempering, purely combinational 32-to-32 (zero latency, no flow control).
module mt32_temper (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    import mt32_pkg::*;

    logic [31:0] y1;
    logic [31:0] y2;
    logic [31:0] y3;

    always_comb begin
        y1   = din ^ (din >> TEMPER_U);
        y2   = y1 ^ ((y1 << TEMPER_S) & TEMPER_B);
        y3   = y2 ^ ((y2 << TEMPER_T) & TEMPER_C);
        dout = y3 ^ (y3 >> TEMPER_L);
    end

endmodule

// File: rtl/mt32_ctrl.sv
// MT19937 sequencer: seeds mt32_mem, then twists one word per step; first word 627 cycles after seed.
// A step only fires when the output register is free or drained; MT32_TEMPER_EN tempers out_data.
module mt32_ctrl #(
    parameter int N       = mt32_pkg::N,
    parameter int M       = mt32_pkg::M,
    parameter int A_WIDTH = mt32_pkg::A_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seed_valid,
    input  logic [31:0]        seed,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [A_WIDTH-1:0] raddr0,
    output logic               ren0,
    input  logic [31:0]        rdata0,
    output logic [A_WIDTH-1:0] raddr1,
    output logic               ren1,
    input  logic [31:0]        rdata1,
    output logic [A_WIDTH-1:0] waddr0,
    output logic               wen0,
    output logic [31:0]        wdata0
);
    import mt32_pkg::*;

    // One spare bit so i+2 and i+M+1 can be compared against N before wrapping.
    typedef logic [A_WIDTH:0] idx_ext_t;

    localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(N - 1);
    localparam logic [A_WIDTH-1:0] ADDR_ONE = A_WIDTH'(1);
    localparam logic [A_WIDTH-1:0] ADDR_M   = A_WIDTH'(M);
    localparam idx_ext_t           N_EXT    = idx_ext_t'(N);
    localparam idx_ext_t           TWO_EXT  = idx_ext_t'(2);
    localparam idx_ext_t           M1_EXT   = idx_ext_t'(M + 1);

    state_t             state;
    state_t             state_nxt;
    logic [A_WIDTH-1:0] idx;
    logic [A_WIDTH-1:0] i;
    logic [31:0]        seed_q;
    logic [31:0]        prev;
    logic [31:0]        cur;

    logic               fire;
    logic [31:0]        seed_word;
    logic [31:0]        y;
    logic [31:0]        new_word;
    logic [31:0]        out_word;
    idx_ext_t           rd0_sum;
    idx_ext_t           rd1_sum;
    logic [A_WIDTH-1:0] rd0_addr;
    logic [A_WIDTH-1:0] rd1_addr;

    // A seed strobe pre-empts the step so no stale word is written or emitted.
    assign fire = (state == ST_RUN) && !seed_valid && (!out_valid || out_ready);

    always_comb begin
        seed_word = (idx == '0) ? seed_q
                                : (INIT_MULT * (prev ^ (prev >> 30))) + 32'(idx);
        y         = (cur & UPPER_MASK) | (rdata0 & LOWER_MASK);
        new_word  = rdata1 ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'h0);
        rd0_sum   = {1'b0, i} + TWO_EXT;
        rd1_sum   = {1'b0, i} + M1_EXT;
        rd0_addr  = (rd0_sum >= N_EXT) ? A_WIDTH'(rd0_sum - N_EXT) : A_WIDTH'(rd0_sum);
        rd1_addr  = (rd1_sum >= N_EXT) ? A_WIDTH'(rd1_sum - N_EXT) : A_WIDTH'(rd1_sum);
    end

`ifdef MT32_TEMPER_EN
    mt32_temper u_temper (
        .din  (new_word),
        .dout (out_word)
    );
`else
    assign out_word = new_word;
`endif

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        ren0      = 1'b0;
        ren1      = 1'b0;
        wen0      = 1'b0;
        raddr0    = '0;
        raddr1    = '0;
        waddr0    = '0;
        wdata0    = '0;
        case (state)
            ST_IDLE: ;
            ST_SEED: begin
                busy   = 1'b1;
                wen0   = 1'b1;
                waddr0 = idx;
                wdata0 = seed_word;
                if (idx == LAST_IDX) state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                busy      = 1'b1;
                ren0      = 1'b1;
                ren1      = 1'b1;
                raddr0    = ADDR_ONE;
                raddr1    = ADDR_M;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (fire) begin
                    wen0   = 1'b1;
                    waddr0 = i;
                    wdata0 = new_word;
                    ren0   = 1'b1;
                    ren1   = 1'b1;
                    raddr0 = rd0_addr;
                    raddr1 = rd1_addr;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (seed_valid) state_nxt = ST_SEED;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            i         <= '0;
            seed_q    <= '0;
            prev      <= '0;
            cur       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (seed_valid) begin
                seed_q    <= seed;
                idx       <= '0;
                out_valid <= 1'b0;
            end else begin
                if (state == ST_SEED) begin
                    prev <= seed_word;
                    idx  <= idx + 1'b1;
                end
                if (state == ST_PRIME) begin
                    i   <= '0;
                    cur <= seed_q;
                end
                if (fire) begin
                    out_data  <= out_word;
                    out_valid <= 1'b1;
                    cur       <= rdata0;
                    i         <= (i == LAST_IDX) ? '0 : i + 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mt32_ctrl.sv
// Bench for mt32_ctrl: behavioural MT19937 reference plus a two-port RAM standing in for mt32_mem.
module tb_mt32_ctrl;

    localparam int NN = 624;
    localparam int MM = 397;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          seed_valid;
    logic [31:0]   seed;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [AW-1:0] raddr0;
    logic          ren0;
    logic [31:0]   rdata0;
    logic [AW-1:0] raddr1;
    logic          ren1;
    logic [31:0]   rdata1;
    logic [AW-1:0] waddr0;
    logic          wen0;
    logic [31:0]   wdata0;

    mt32_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid),
        .seed       (seed),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .raddr0     (raddr0),
        .ren0       (ren0),
        .rdata0     (rdata0),
        .raddr1     (raddr1),
        .ren1       (ren1),
        .rdata1     (rdata1),
        .waddr0     (waddr0),
        .wen0       (wen0),
        .wdata0     (wdata0)
    );

    always #5 clk = ~clk;

    // Two read ports with 1-cycle latency, data held while the enable is low.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ren0) rdata0 <= mem[raddr0];
        if (ren1) rdata1 <= mem[raddr1];
        if (wen0) mem[waddr0] <= wdata0;
    end

    int checks   = 0;
    int failures = 0;
    int accepted = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference generator in the style of the C implementation: full init, then in-place twist.
    logic [31:0] mt_ref [0:NN-1];
    int          kk;

    task automatic model_seed(input logic [31:0] s);
        mt_ref[0] = s;
        for (int j = 1; j < NN; j++)
            mt_ref[j] = 32'd1812433253 * (mt_ref[j-1] ^ (mt_ref[j-1] >> 30)) + 32'(j);
        kk = 0;
    endtask

    function automatic logic [31:0] model_next();
        logic [31:0] yy;
        yy = (mt_ref[kk] & 32'h8000_0000) | (mt_ref[(kk + 1) % NN] & 32'h7FFF_FFFF);
        mt_ref[kk] = mt_ref[(kk + MM) % NN] ^ (yy >> 1) ^ (yy[0] ? 32'h9908_B0DF : 32'h0);
        model_next = mt_ref[kk];
        kk = (kk + 1) % NN;
    endfunction

    function automatic logic [31:0] temper(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        t = t ^ (t >> 11);
        t = t ^ ((t << 7) & 32'h9D2C_5680);
        t = t ^ ((t << 15) & 32'hEFC6_0000);
        t = t ^ (t >> 18);
        return t;
    endfunction

    function automatic logic [31:0] expect_out(input logic [31:0] w);
`ifdef MT32_TEMPER_EN
        return temper(w);
`else
        return w;
`endif
    endfunction

    // Single compare process: every cycle is checked against the reference stream.
    logic [31:0] q [$];
    bit          active = 1'b0;
    int          sidx   = 0;

    always @(negedge clk) begin
        logic [31:0] w;
        if (!reset) begin
            active = 1'b0;
            q.delete();
        end else if (seed_valid) begin
            model_seed(seed);
            active = 1'b1;
            sidx   = 0;
            q.delete();
        end else if (!active) begin
            chk("idle_quiet", 64'({busy, out_valid, ren0, ren1, wen0}), 64'(0));
        end else begin
            chk("valid_vs_pending", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("dup_word", 64'(1), 64'(0));
                end else begin
                    w = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(expect_out(w)));
                end
                accepted++;
            end
            if (busy && wen0) begin
                chk("seed_waddr", 64'(waddr0), 64'(sidx));
                chk("seed_wdata", 64'(wdata0), 64'(mt_ref[sidx]));
                sidx++;
            end
            if (!busy && out_valid && !out_ready)
                chk("stall_quiet", 64'({ren0, ren1, wen0}), 64'(0));
            if (!busy && wen0) begin
                chk("run_waddr", 64'(waddr0), 64'(kk));
                w = model_next();
                chk("run_wdata", 64'(wdata0), 64'(w));
                q.push_back(w);
                chk("lost_word", 64'(q.size() <= 1), 64'(1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_data"},  64'(out_data),  64'(0));
        chk({tag, "_raddr0"},    64'(raddr0),    64'(0));
        chk({tag, "_ren0"},      64'(ren0),      64'(0));
        chk({tag, "_raddr1"},    64'(raddr1),    64'(0));
        chk({tag, "_ren1"},      64'(ren1),      64'(0));
        chk({tag, "_waddr0"},    64'(waddr0),    64'(0));
        chk({tag, "_wen0"},      64'(wen0),      64'(0));
        chk({tag, "_wdata0"},    64'(wdata0),    64'(0));
    endtask

    // Seed strobe in cycle 0, then count busy cycles and find the first out_valid cycle.
    task automatic seed_timed(input logic [31:0] s, output int bc, output int fv);
        seed       = s;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        bc = 0;
        fv = 0;
        for (int n = 1; n <= 800 && fv == 0; n++) begin
            @(negedge clk);
            if (n == 1) chk("valid_drop_after_seed", 64'(out_valid), 64'(0));
            if (busy) bc++;
            if (out_valid) fv = n;
            tick();
        end
    endtask

    task automatic wait_accept(input int count, input bit rnd);
        int target;
        int n;
        target = accepted + count;
        n = 0;
        while (accepted < target && n < 20000) begin
            tick();
            if (rnd) out_ready = ($urandom_range(0, 99) >= 30);
            n++;
        end
        out_ready = 1'b1;
        chk("accept_budget", 64'(accepted >= target), 64'(1));
    endtask

    initial begin
        int          bc;
        int          fv;
        logic [31:0] w0;
        logic [31:0] w1;

        reset      = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        out_ready  = 1'b1;

        // Hand-computed anchors for the reference model.
        model_seed(32'd5489);
        chk("pin_mt1", 64'(mt_ref[1]), 64'(32'd1301868182));
        w0 = model_next();
        w1 = model_next();
        chk("pin_tempered0", 64'(temper(w0)), 64'(32'd3499211612));
        chk("pin_tempered1", 64'(temper(w1)), 64'(32'd581869302));

        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        reset = 1'b1;
        repeat (5) tick();

        // Seed 5489, full-rate consumer, cross the N-word wrap.
        seed_timed(32'd5489, bc, fv);
        chk("busy_cycles", 64'(bc), 64'(625));
        chk("first_valid_cycle", 64'(fv), 64'(627));
        wait_accept(1000, 1'b0);

        // Random backpressure.
        wait_accept(2000, 1'b1);

        // Reseed mid-RUN while a word is pending.
        for (int n = 0; n < 50 && !out_valid; n++) tick();
        chk("valid_before_reseed", 64'(out_valid), 64'(1));
        seed_timed(32'd1, bc, fv);
        chk("reseed_busy_cycles", 64'(bc), 64'(625));
        chk("reseed_first_valid", 64'(fv), 64'(627));
        wait_accept(50, 1'b0);

        // Reset in the middle of seeding.
        seed       = 32'd7;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        repeat (100) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check_all_zero("midseed_reset");
        reset = 1'b1;
        repeat (20) tick();
        chk("stays_idle", 64'({busy, out_valid, wen0}), 64'(0));

        seed_timed(32'd42, bc, fv);
        chk("after_reset_first_valid", 64'(fv), 64'(627));
        wait_accept(700, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
